ahb_burst_master: RTL and testbench

Single-port AHB (AMBA 2) bus master engine that sits directly upstream of the bus arbiter. It drives one HBUSREQx/HLOCKx pair and consumes the matching HGRANTx bit. It turns a simple command (address, length, direction, lock) into a compliant pipelined incrementing burst. It handles wait states, grant loss mid-burst, 1 KB boundary splitting and two-cycle RETRY/SPLIT/ERROR responses.

---
 rtl/ahb_pkg.sv | 40 ++++
 rtl/ahb_burst_planner.sv | 39 +++
 rtl/ahb_burst_master.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_ahb_burst_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB (AMBA 2) encodings, fixed control values and the burst-master FSM states.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'b00,
    HR_ERROR = 2'b01,
    HR_RETRY = 2'b10,
    HR_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_t;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA_LAST,
    ST_RESP2
  } fsm_state_t;

endpackage

// File: rtl/ahb_burst_planner.sv
// Chooses HBURST for a segment about to start with NONSEQ and reports whether the
// remaining beats would run past the next BOUNDARY-aligned address.
module ahb_burst_planner
  import ahb_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int BOUNDARY = 1024
) (
  input  logic [$clog2(MAX_LEN):0] rem_beats,
  input  logic [31:0]              addr,
  input  logic                     first_seg,
  output hburst_t                  hburst,
  output logic                     crosses
);

  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam logic [31:0] BOUND_MASK = 32'(BOUNDARY - 1);
  localparam logic [31:0] BOUND_U    = 32'(BOUNDARY);

  logic [31:0] span_end;

  // Fixed-length bursts only for an untouched first segment that stays inside one boundary window.
  always_comb begin
    span_end = (addr & BOUND_MASK) + (32'(rem_beats) << 2);
    crosses  = (span_end > BOUND_U);
    hburst   = HB_INCR;
    if (rem_beats == LW'(1)) begin
      hburst = HB_SINGLE;
    end else if (first_seg && !crosses) begin
      case (rem_beats)
        LW'(4):  hburst = HB_INCR4;
        LW'(8):  hburst = HB_INCR8;
        LW'(16): hburst = HB_INCR16;
        default: hburst = HB_INCR;
      endcase
    end
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB burst master: turns one command into pipelined incrementing bursts, coping with
// wait states, grant loss, boundary splits and two-cycle RETRY/SPLIT/ERROR responses.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int BOUNDARY = 1024
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [31:0]                cmd_addr,
  input  logic [$clog2(MAX_LEN):0]   cmd_len,
  input  logic                       cmd_lock,
  output logic [$clog2(MAX_LEN)-1:0] wr_beat,
  input  logic [31:0]                wr_data,
  output logic                       rd_valid,
  output logic [31:0]                rd_data,
  output logic [$clog2(MAX_LEN)-1:0] rd_beat,
  output logic                       done,
  output logic                       err,
  output logic                       HBUSREQ,
  output logic                       HLOCK,
  input  logic                       HGRANT,
  input  logic                       HREADY,
  input  logic [1:0]                 HRESP,
  input  logic [31:0]                HRDATA,
  output logic [31:0]                HADDR,
  output logic [1:0]                 HTRANS,
  output logic                       HWRITE,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [3:0]                 HPROT,
  output logic [31:0]                HWDATA
);

  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [31:0] BOUND_MASK = 32'(BOUNDARY - 1);

  // Command context
  fsm_state_t    state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [LW-1:0] len_q, len_d;
  logic          write_q, write_d;
  logic          lock_q, lock_d;
  logic          first_seg_q, first_seg_d;
  // Address-phase beat index: beat on HADDR in ADDR, next beat to issue in REQ
  logic [IW-1:0] a_idx_q, a_idx_d;
  // Data-phase tracking
  logic          d_vld_q, d_vld_d;
  logic [IW-1:0] d_idx_q, d_idx_d;
  logic          d_write_q, d_write_d;
  logic          resp_err_q, resp_err_d;
  // Registered bus and user outputs
  logic          hbusreq_q, hbusreq_d;
  logic          hlock_q, hlock_d;
  htrans_t       htrans_q, htrans_d;
  logic [31:0]   haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  hburst_t       hburst_q, hburst_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [IW-1:0] rd_beat_q, rd_beat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  hresp_t        resp_in;
  logic          resp_first;
  logic          beat_ok;
  logic          a_last;
  logic [31:0]   plan_addr;
  logic [LW-1:0] plan_rem;
  hburst_t       plan_burst;
  logic          plan_cross;

  assign resp_in = hresp_t'(HRESP);
  // First cycle of a two-cycle response: slave holds HREADY low with a non-OKAY code.
  assign resp_first = d_vld_q && !HREADY && (resp_in != HR_OKAY) && (state_q != ST_RESP2);
  assign beat_ok    = d_vld_q && HREADY && (resp_in == HR_OKAY) && (state_q != ST_RESP2);
  assign a_last     = (LW'(a_idx_q) == (len_q - LW'(1)));

  // In ADDR the planner looks at the beat that would follow the one on the bus;
  // in REQ it looks at the beat that the next NONSEQ will carry.
  assign plan_addr = (state_q == ST_ADDR) ? (haddr_q + 32'd4)
                                          : (base_q + (32'(a_idx_q) << 2));
  assign plan_rem  = (state_q == ST_ADDR) ? (len_q - LW'(a_idx_q) - LW'(1))
                                          : (len_q - LW'(a_idx_q));

  ahb_burst_planner #(
    .MAX_LEN  (MAX_LEN),
    .BOUNDARY (BOUNDARY)
  ) u_planner (
    .rem_beats (plan_rem),
    .addr      (plan_addr),
    .first_seg (first_seg_q),
    .hburst    (plan_burst),
    .crosses   (plan_cross)
  );

  // Next-state and next-output computation for the whole engine.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    write_d     = write_q;
    lock_d      = lock_q;
    first_seg_d = first_seg_q;
    a_idx_d     = a_idx_q;
    d_vld_d     = d_vld_q;
    d_idx_d     = d_idx_q;
    d_write_d   = d_write_q;
    resp_err_d  = resp_err_q;
    hbusreq_d   = hbusreq_q;
    hlock_d     = hlock_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hburst_d    = hburst_q;
    cmd_ready_d = cmd_ready_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_beat_d   = rd_beat_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // A data beat retiring OKAY frees the data phase; reads are reported next cycle.
    if (beat_ok) begin
      d_vld_d = 1'b0;
      if (!d_write_q) begin
        rd_valid_d = 1'b1;
        rd_data_d  = HRDATA;
        rd_beat_d  = d_idx_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          base_d      = cmd_addr & ~32'h3;
          len_d       = (cmd_len == '0) ? LW'(1) : cmd_len;
          write_d     = cmd_write;
          lock_d      = cmd_lock;
          first_seg_d = 1'b1;
          a_idx_d     = '0;
          hbusreq_d   = 1'b1;
          hlock_d     = cmd_lock;
          cmd_ready_d = 1'b0;
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        if (resp_first) begin
          htrans_d   = HT_IDLE;
          resp_err_d = (resp_in == HR_ERROR);
          state_d    = ST_RESP2;
        end else if (HREADY && HGRANT) begin
          htrans_d    = HT_NONSEQ;
          haddr_d     = plan_addr;
          hwrite_d    = write_q;
          hburst_d    = plan_burst;
          first_seg_d = 1'b0;
          state_d     = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (resp_first) begin
          htrans_d   = HT_IDLE;
          resp_err_d = (resp_in == HR_ERROR);
          state_d    = ST_RESP2;
        end else if (HREADY) begin
          d_vld_d   = 1'b1;
          d_idx_d   = a_idx_q;
          d_write_d = write_q;
          if (a_last) begin
            htrans_d  = HT_IDLE;
            hbusreq_d = 1'b0;
            hlock_d   = 1'b0;
            state_d   = ST_DATA_LAST;
          end else begin
            a_idx_d = a_idx_q + IW'(1);
            if (!HGRANT) begin
              htrans_d = HT_IDLE;
              state_d  = ST_REQ;
            end else if ((plan_addr & BOUND_MASK) == 32'd0) begin
              htrans_d = HT_NONSEQ;
              haddr_d  = plan_addr;
              hburst_d = plan_burst;
            end else begin
              htrans_d = HT_SEQ;
              haddr_d  = plan_addr;
            end
          end
        end
      end

      ST_DATA_LAST: begin
        if (resp_first) begin
          htrans_d   = HT_IDLE;
          resp_err_d = (resp_in == HR_ERROR);
          state_d    = ST_RESP2;
        end else if (beat_ok) begin
          done_d      = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_RESP2: begin
        // Second response cycle: the failed beat and any pipelined beat are dropped.
        if (HREADY) begin
          d_vld_d  = 1'b0;
          htrans_d = HT_IDLE;
          if (resp_err_q) begin
            hbusreq_d   = 1'b0;
            hlock_d     = 1'b0;
            err_d       = 1'b1;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            a_idx_d   = d_idx_q;
            hbusreq_d = 1'b1;
            hlock_d   = lock_q;
            state_d   = ST_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset forces the idle bus image immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      write_q     <= 1'b0;
      lock_q      <= 1'b0;
      first_seg_q <= 1'b0;
      a_idx_q     <= '0;
      d_vld_q     <= 1'b0;
      d_idx_q     <= '0;
      d_write_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      hbusreq_q   <= 1'b0;
      hlock_q     <= 1'b0;
      htrans_q    <= HT_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hburst_q    <= HB_SINGLE;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_beat_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      write_q     <= write_d;
      lock_q      <= lock_d;
      first_seg_q <= first_seg_d;
      a_idx_q     <= a_idx_d;
      d_vld_q     <= d_vld_d;
      d_idx_q     <= d_idx_d;
      d_write_q   <= d_write_d;
      resp_err_q  <= resp_err_d;
      hbusreq_q   <= hbusreq_d;
      hlock_q     <= hlock_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hburst_q    <= hburst_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_beat_q   <= rd_beat_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // A segment that would run past a boundary must never carry a fixed-length burst code.
  assert property (@(posedge HCLK) disable iff (!HRESETn)
                   plan_cross |-> (plan_burst == HB_INCR || plan_burst == HB_SINGLE));

  // The pipelined address beat is withdrawn as soon as a two-cycle response starts.
  assign HTRANS    = resp_first ? HT_IDLE : htrans_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HBURST    = hburst_q;
  assign HSIZE     = HSIZE_WORD;
  assign HPROT     = HPROT_DEFAULT;
  assign HWDATA    = (d_vld_q && d_write_q) ? wr_data : 32'd0;
  assign HBUSREQ   = hbusreq_q;
  assign HLOCK     = hlock_q;
  assign cmd_ready = cmd_ready_q;
  assign wr_beat   = d_idx_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_beat   = rd_beat_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: bench drives arbiter/slave signals cycle by cycle.
module tb_ahb_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_lock;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [3:0]  wr_beat, rd_beat;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, done, err;
  logic        HBUSREQ, HLOCK, HGRANT, HREADY, HWRITE;
  logic [1:0]  HRESP, HTRANS;
  logic [31:0] HRDATA, HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  localparam logic [31:0] T_IDLE = 32'd0;
  localparam logic [31:0] T_NSQ  = 32'd2;
  localparam logic [31:0] T_SEQ  = 32'd3;

  int n_chk  = 0;
  int n_fail = 0;
  int n_seq;
  int n_done;

  logic [31:0] dph_addr = 32'd0;

  ahb_burst_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_lock  (cmd_lock),
    .wr_beat   (wr_beat),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_beat   (rd_beat),
    .done      (done),
    .err       (err),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HGRANT    (HGRANT),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA)
  );

  always #5 HCLK = ~HCLK;

  // Write source: data word tagged with the beat index the master asks for.
  assign wr_data = 32'hA000_0000 | {28'h0, wr_beat};

  // Slave model: read data derived from the address accepted into the data phase.
  always @(posedge HCLK) if (HREADY) dph_addr <= HADDR;
  assign HRDATA = 32'hC0DE_0000 ^ dph_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic start_cmd(input logic w, input logic [31:0] a, input logic [4:0] l, input logic lk);
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_lock  = lk;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'd0;
    cmd_len   = 5'd0;
    cmd_lock  = 1'b0;
    HGRANT    = 1'b1;
    HREADY    = 1'b1;
    HRESP     = 2'b00;
    step();
    step();

    // Reset image
    chk("rst_hbusreq", 32'(HBUSREQ), 32'd0);
    chk("rst_htrans", 32'(HTRANS), T_IDLE);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd2);
    chk("rst_hprot", 32'(HPROT), 32'd3);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    HRESETn = 1'b1;
    step();

    // Test 1: write len 4 at 0x100, INCR4
    start_cmd(1'b1, 32'h100, 5'd4, 1'b0);
    chk("t1_req_busreq", 32'(HBUSREQ), 32'd1);
    chk("t1_req_ready", 32'(cmd_ready), 32'd0);
    chk("t1_req_htrans", 32'(HTRANS), T_IDLE);
    step();
    chk("t1_nonseq", 32'(HTRANS), T_NSQ);
    chk("t1_addr0", HADDR, 32'h100);
    chk("t1_hburst", 32'(HBURST), 32'd3);
    chk("t1_hwrite", 32'(HWRITE), 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t1_seq", 32'(HTRANS), T_SEQ);
      chk("t1_addr", HADDR, 32'h100 + 32'(4 * i));
      chk("t1_wr_beat", 32'(wr_beat), 32'(i - 1));
      chk("t1_hwdata", HWDATA, 32'hA000_0000 + 32'(i - 1));
    end
    step();
    chk("t1_last_idle", 32'(HTRANS), T_IDLE);
    chk("t1_busreq_drop", 32'(HBUSREQ), 32'd0);
    chk("t1_hwdata3", HWDATA, 32'hA000_0003);
    chk("t1_no_done_yet", 32'(done), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Test 2: read len 8 at 0x3F0, split at 0x400
    start_cmd(1'b0, 32'h3F0, 5'd8, 1'b0);
    for (int k = 2; k <= 11; k++) begin
      step();
      if (k <= 9) begin
        chk("t2_htrans", 32'(HTRANS), ((k - 2) == 0 || (k - 2) == 4) ? T_NSQ : T_SEQ);
        chk("t2_haddr", HADDR, 32'h3F0 + 32'(4 * (k - 2)));
        if ((k - 2) == 0 || (k - 2) == 4) chk("t2_hburst", 32'(HBURST), 32'd1);
      end else begin
        chk("t2_end_idle", 32'(HTRANS), T_IDLE);
      end
      if (k >= 4) begin
        chk("t2_rd_valid", 32'(rd_valid), 32'd1);
        chk("t2_rd_beat", 32'(rd_beat), 32'(k - 4));
        chk("t2_rd_data", rd_data, 32'hC0DE_0000 ^ (32'h3F0 + 32'(4 * (k - 4))));
      end else begin
        chk("t2_rd_idle", 32'(rd_valid), 32'd0);
      end
      chk("t2_done", 32'(done), 32'(k == 11));
    end
    step();

    // Test 3: write len 16 at 0x200, grant lost after 5th address beat
    start_cmd(1'b1, 32'h200, 5'd16, 1'b0);
    step();
    chk("t3_nonseq", 32'(HTRANS), T_NSQ);
    chk("t3_hburst16", 32'(HBURST), 32'd7);
    for (int i = 0; i < 4; i++) step();
    chk("t3_beat4", HADDR, 32'h210);
    HGRANT = 1'b0;
    step();
    chk("t3_lost_idle", 32'(HTRANS), T_IDLE);
    chk("t3_busreq_held", 32'(HBUSREQ), 32'd1);
    chk("t3_wr_beat4", 32'(wr_beat), 32'd4);
    step();
    chk("t3_wait1", 32'(HTRANS), T_IDLE);
    step();
    chk("t3_wait2", 32'(HTRANS), T_IDLE);
    HGRANT = 1'b1;
    step();
    chk("t3_resume", 32'(HTRANS), T_NSQ);
    chk("t3_resume_addr", HADDR, 32'h214);
    chk("t3_resume_burst", 32'(HBURST), 32'd1);
    n_seq  = 0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (HTRANS == 2'b11) n_seq++;
      if (done) n_done++;
    end
    chk("t3_seq_beats", 32'(n_seq), 32'd10);
    chk("t3_done_count", 32'(n_done), 32'd1);

    // Test 4: read len 4 at 0x300, RETRY on beat 2
    start_cmd(1'b0, 32'h300, 5'd4, 1'b0);
    step();
    chk("t4_nonseq", 32'(HTRANS), T_NSQ);
    chk("t4_hburst", 32'(HBURST), 32'd3);
    step();
    step();
    chk("t4_rd0", 32'(rd_beat), 32'd0);
    step();
    chk("t4_beat3_addr", HADDR, 32'h30C);
    chk("t4_rd1_valid", 32'(rd_valid), 32'd1);
    chk("t4_rd1", 32'(rd_beat), 32'd1);
    HREADY = 1'b0;
    HRESP  = 2'b10;
    #1;
    chk("t4_idle_first", 32'(HTRANS), T_IDLE);
    step();
    chk("t4_idle_second", 32'(HTRANS), T_IDLE);
    chk("t4_busreq", 32'(HBUSREQ), 32'd1);
    chk("t4_no_rd", 32'(rd_valid), 32'd0);
    HREADY = 1'b1;
    step();
    HRESP = 2'b00;
    chk("t4_req_idle", 32'(HTRANS), T_IDLE);
    chk("t4_no_rd2", 32'(rd_valid), 32'd0);
    step();
    chk("t4_restart", 32'(HTRANS), T_NSQ);
    chk("t4_restart_addr", HADDR, 32'h308);
    chk("t4_restart_burst", 32'(HBURST), 32'd1);
    step();
    chk("t4_seq", HADDR, 32'h30C);
    step();
    chk("t4_rd2", 32'(rd_beat), 32'd2);
    chk("t4_rd2_data", rd_data, 32'hC0DE_0308);
    step();
    chk("t4_rd3", 32'(rd_beat), 32'd3);
    chk("t4_done", 32'(done), 32'd1);
    step();

    // Test 5: locked write len 4 at 0x400, ERROR on beat 1
    start_cmd(1'b1, 32'h400, 5'd4, 1'b1);
    chk("t5_hlock", 32'(HLOCK), 32'd1);
    step();
    step();
    step();
    chk("t5_wr_beat1", 32'(wr_beat), 32'd1);
    HREADY = 1'b0;
    HRESP  = 2'b01;
    #1;
    chk("t5_idle_first", 32'(HTRANS), T_IDLE);
    step();
    HREADY = 1'b1;
    step();
    HRESP = 2'b00;
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_no_done", 32'(done), 32'd0);
    chk("t5_busreq", 32'(HBUSREQ), 32'd0);
    chk("t5_hlock_drop", 32'(HLOCK), 32'd0);
    chk("t5_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("t5_err_pulse", 32'(err), 32'd0);

    // Test 6: len 0 read at unaligned 0x603 -> single beat at 0x600
    start_cmd(1'b0, 32'h603, 5'd0, 1'b0);
    step();
    chk("t6_nonseq", 32'(HTRANS), T_NSQ);
    chk("t6_addr", HADDR, 32'h600);
    chk("t6_single", 32'(HBURST), 32'd0);
    step();
    chk("t6_busreq_drop", 32'(HBUSREQ), 32'd0);
    step();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_rd_data", rd_data, 32'hC0DE_0600);
    step();

    // Test 7: asynchronous reset in the middle of a locked burst
    start_cmd(1'b1, 32'h500, 5'd8, 1'b1);
    step();
    step();
    step();
    chk("t7_pre_seq", 32'(HTRANS), T_SEQ);
    HRESETn = 1'b0;
    #1;
    chk("t7_htrans", 32'(HTRANS), T_IDLE);
    chk("t7_hbusreq", 32'(HBUSREQ), 32'd0);
    chk("t7_hlock", 32'(HLOCK), 32'd0);
    chk("t7_haddr", HADDR, 32'd0);
    chk("t7_hwdata", HWDATA, 32'd0);
    chk("t7_wr_beat", 32'(wr_beat), 32'd0);
    chk("t7_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("t7_no_done", 32'(done), 32'd0);
    chk("t7_no_err", 32'(err), 32'd0);
    HRESETn = 1'b1;
    step();
    chk("t7_idle_after", 32'(HTRANS), T_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
